// File: rtl/mult13x8_pkg.sv
// mult13x8_pkg: shared constants for the 13x8 carry-save multiplier.
//   A_W     - multiplicand width
//   B_W     - multiplier width (one partial-product row per bit)
//   P_W     - product / carry-save vector width
//   LATENCY - clock edges from operand sampling to result on out1/out2
// Build option: MULT13X8_IN_REG_EN adds an operand register stage (latency 2).
package mult13x8_pkg;

    localparam int unsigned A_W = 13;
    localparam int unsigned B_W = 8;
    localparam int unsigned P_W = 21;

`ifdef MULT13X8_IN_REG_EN
    localparam int unsigned LATENCY = 2;
`else
    localparam int unsigned LATENCY = 1;
`endif

endpackage

// File: rtl/csa_fa.sv
// csa_fa: 1-bit full adder used as the 3:2 compressor cell of the reduction tree.
// Ports:
//   a, b, ci - three bits of equal weight
//   s        - sum bit (same weight)
//   co       - carry bit (next weight up)
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign s    = ab_x ^ ci;
    assign co   = (a & b) | (ci & ab_x);

endmodule

// File: rtl/mult13x8.sv
// mult13x8: unsigned 13x8 multiplier producing A*B in carry-save form.
// The consumer forms the product as out1 + out2; there is no final adder here.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, clears every register
//   A    - 13-bit unsigned multiplicand
//   B    - 8-bit unsigned multiplier
//   out1 - 21-bit registered sum vector
//   out2 - 21-bit registered carry vector (bit 0 always 0)
// Build option: MULT13X8_IN_REG_EN registers A/B before the tree (latency 2,
// otherwise latency 1). Results are identical either way.
module mult13x8
    import mult13x8_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic [P_W-1:0] out1,
    output logic [P_W-1:0] out2
);

    // Operand stage
    logic [A_W-1:0] a_op;
    logic [B_W-1:0] b_op;

`ifdef MULT13X8_IN_REG_EN
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    assign a_op = a_q;
    assign b_op = b_q;
`else
    assign a_op = A;
    assign b_op = B;
`endif

    // Partial products: row i is (A AND B[i]) << i
    logic [P_W-1:0] pp [B_W];

    for (genvar i = 0; i < B_W; i++) begin : g_pp
        assign pp[i] = {{(P_W-A_W){1'b0}}, a_op & {A_W{b_op[i]}}} << i;
    end

    // Reduction tree, 8 rows -> 2 in four 3:2 levels:
    //   L1: (pp0,pp1,pp2) (pp3,pp4,pp5)            -> 4 rows, pp6/pp7 pass
    //   L2: (s0,c0,s1)    (c1,pp6,pp7)             -> 4 rows
    //   L3: (s0,c0,s1)                              -> 3 rows with c1 passing
    //   L4: (s,c,c1 of L2)                          -> final sum/carry
    // Each compressor works mod 2^21: the MSB column keeps only its sum bit,
    // since its carry would land at weight 2^21.
    logic [P_W-1:0] lv1_s [2];
    logic [P_W-1:0] lv1_c [2];
    logic [P_W-1:0] lv2_in [6];
    logic [P_W-1:0] lv2_s [2];
    logic [P_W-1:0] lv2_c [2];
    logic [P_W-1:0] lv3_s;
    logic [P_W-1:0] lv3_c;
    logic [P_W-1:0] sum_d;
    logic [P_W-1:0] carry_d;

    for (genvar j = 0; j < 2; j++) begin : g_lv1
        logic [P_W-2:0] co;
        for (genvar k = 0; k < P_W-1; k++) begin : g_bit
            csa_fa u_fa (
                .a  (pp[3*j][k]),
                .b  (pp[3*j+1][k]),
                .ci (pp[3*j+2][k]),
                .s  (lv1_s[j][k]),
                .co (co[k])
            );
        end
        assign lv1_s[j][P_W-1] = pp[3*j][P_W-1] ^ pp[3*j+1][P_W-1] ^ pp[3*j+2][P_W-1];
        assign lv1_c[j]        = {co, 1'b0};
    end

    assign lv2_in[0] = lv1_s[0];
    assign lv2_in[1] = lv1_c[0];
    assign lv2_in[2] = lv1_s[1];
    assign lv2_in[3] = lv1_c[1];
    assign lv2_in[4] = pp[6];
    assign lv2_in[5] = pp[7];

    for (genvar j = 0; j < 2; j++) begin : g_lv2
        logic [P_W-2:0] co;
        for (genvar k = 0; k < P_W-1; k++) begin : g_bit
            csa_fa u_fa (
                .a  (lv2_in[3*j][k]),
                .b  (lv2_in[3*j+1][k]),
                .ci (lv2_in[3*j+2][k]),
                .s  (lv2_s[j][k]),
                .co (co[k])
            );
        end
        assign lv2_s[j][P_W-1] =
            lv2_in[3*j][P_W-1] ^ lv2_in[3*j+1][P_W-1] ^ lv2_in[3*j+2][P_W-1];
        assign lv2_c[j] = {co, 1'b0};
    end

    logic [P_W-2:0] lv3_co;

    for (genvar k = 0; k < P_W-1; k++) begin : g_lv3
        csa_fa u_fa (
            .a  (lv2_s[0][k]),
            .b  (lv2_c[0][k]),
            .ci (lv2_s[1][k]),
            .s  (lv3_s[k]),
            .co (lv3_co[k])
        );
    end
    assign lv3_s[P_W-1] = lv2_s[0][P_W-1] ^ lv2_c[0][P_W-1] ^ lv2_s[1][P_W-1];
    assign lv3_c        = {lv3_co, 1'b0};

    logic [P_W-2:0] lv4_co;

    for (genvar k = 0; k < P_W-1; k++) begin : g_lv4
        csa_fa u_fa (
            .a  (lv3_s[k]),
            .b  (lv3_c[k]),
            .ci (lv2_c[1][k]),
            .s  (sum_d[k]),
            .co (lv4_co[k])
        );
    end
    assign sum_d[P_W-1] = lv3_s[P_W-1] ^ lv3_c[P_W-1] ^ lv2_c[1][P_W-1];
    assign carry_d      = {lv4_co, 1'b0};

    // Output register
    logic [P_W-1:0] sum_q;
    logic [P_W-1:0] carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign out1 = sum_q;
    assign out2 = carry_q;

endmodule

// File: tb/tb_mult13x8.sv
// tb_mult13x8: self-checking bench for mult13x8 (works with or without
// MULT13X8_IN_REG_EN; expected timing follows mult13x8_pkg::LATENCY).
module tb_mult13x8;
    import mult13x8_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic [P_W-1:0] out1;
    logic [P_W-1:0] out2;

    mult13x8 u_dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .out1 (out1),
        .out2 (out2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int pipe0 = 0;
    int pipe1 = 0;
    int exp_now = 0;
    int sum_log [64];
    int lsb_log [64];

    // Hand-computed directed vectors: {A, B, A*B}
    int vec_a [6] = '{1234, 8191, 1,   4095, 5461,   2730};
    int vec_b [6] = '{56,   1,    255, 2,    170,    85};
    int vec_p [6] = '{69104, 8191, 255, 8190, 928370, 232050};

    int corner_a [6] = '{0, 1, 4095, 4096, 8190, 8191};
    int corner_b [6] = '{0, 1, 127, 128, 254, 255};
    int sweep_b  [4] = '{1, 2, 128, 255};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // One clock: drive operands, advance the reference delay line, then log
    // the observed sum just after the edge.
    task automatic cyc(input int a, input int b, input bit r);
        A   = A_W'(a);
        B   = B_W'(b);
        rst = r;
        @(posedge clk);
        if (r) begin
            pipe0 = 0;
            pipe1 = 0;
        end else begin
            pipe1 = pipe0;
            pipe0 = a * b;
        end
        exp_now = (LATENCY == 1) ? pipe0 : pipe1;
        #1;
        t++;
        sum_log[t % 64] = int'(out1) + int'(out2);
        lsb_log[t % 64] = int'(out2[0]);
    endtask

    int t0;
    int mid;

    initial begin
        A   = '0;
        B   = '0;
        rst = 1'b1;

        // Reset state
        cyc(1234, 56, 1);
        cyc(8191, 255, 1);
        check("rst_out1", int'(out1), 0);
        check("rst_out2", int'(out2), 0);

        // Back-to-back directed operands; op issued at cycle t0+i shows up at
        // log index t0+i+LATENCY-1.
        cyc(3, 3, 0);
        t0 = t + 1;
        cyc(0, 0, 0);
        cyc(8191, 255, 0);
        cyc(4096, 128, 0);
        cyc(1, 200, 0);
        cyc(2, 2, 0);
        cyc(2, 2, 0);
        check("zero",      sum_log[(t0 + LATENCY - 1) % 64], 0);
        check("max",       sum_log[(t0 + LATENCY) % 64], 2088705);
        check("max_o2lsb", lsb_log[(t0 + LATENCY) % 64], 0);
        check("p524288",   sum_log[(t0 + 1 + LATENCY) % 64], 524288);
        check("p200",      sum_log[(t0 + 2 + LATENCY) % 64], 200);

        t0 = t + 1;
        for (int i = 0; i < 6; i++) cyc(vec_a[i], vec_b[i], 0);
        repeat (2) cyc(0, 0, 0);
        for (int i = 0; i < 6; i++) check("vec", sum_log[(t0 + i + LATENCY - 1) % 64], vec_p[i]);

        // Corner operands, then a random stream with a one-cycle reset pulse
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                cyc(corner_a[i], corner_b[j], 0);
                check("corner", sum_log[t % 64], exp_now);
                check("corner_o2lsb", lsb_log[t % 64], 0);
            end
        end

        mid = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                cyc(int'($urandom_range(8191)), int'($urandom_range(255)), 1);
                check("midrst_out1", int'(out1), 0);
                check("midrst_out2", int'(out2), 0);
                mid++;
            end
            cyc(int'($urandom_range(8191)), int'($urandom_range(255)), 0);
            check("stream", sum_log[t % 64], exp_now);
            check("stream_o2lsb", lsb_log[t % 64], 0);
        end
        check("midrst_seen", mid, 1);

        // Exhaustive A for selected B values
        for (int j = 0; j < 4; j++) begin
            for (int a = 0; a < 8192; a++) begin
                cyc(a, sweep_b[j], 0);
                check("sweep", sum_log[t % 64], exp_now);
            end
        end
        repeat (2) begin
            cyc(0, 0, 0);
            check("flush", sum_log[t % 64], exp_now);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
